// File: rtl/display_pkg.sv
// Shared types and the seven-segment decoder used by the display stage.
// Segments are active-low with bit0 = a through bit6 = g.
package display_pkg;

    typedef logic [6:0] seg_t;

    typedef enum logic [1:0] {
        S_REG,
        S_BUS,
        S_DONE
    } state_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        seg_t seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/display_debounce.sv
// Two-flop synchroniser for the asynchronous PEEKb switch followed by a
// debouncer that accepts a new level only after DEB_CYCLES stable samples.
module display_debounce #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_raw,
    output logic o_pk
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_pk;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_pk    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // Count consecutive disagreements; any agreement restarts the window.
            if (r_sync2 != r_pk) begin
                if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
                    r_pk  <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_pk = r_pk;

endmodule

// File: rtl/display_ctrl.sv
// Display stage: registered bus LEDs, hex readout of REG/BUS/snapshot, timestep
// digit and a blinking DONE indicator, with a debounced PEEKb source select.
module display_ctrl
    import display_pkg::*;
#(
    parameter int unsigned DATA_W       = 10,
    parameter int unsigned NUM_DIG      = (DATA_W + 3) / 4,
    parameter int unsigned TIME_W       = 2,
    parameter int unsigned DEB_CYCLES   = 16,
    parameter int unsigned BLINK_CYCLES = 2_500_000
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [DATA_W-1:0]    BUS,
    input  logic [DATA_W-1:0]    REG,
    input  logic [TIME_W-1:0]    TIME,
    input  logic                 PEEKb,
    input  logic                 DONE,
    output logic [DATA_W-1:0]    LED_B,
    output logic [NUM_DIG*7-1:0] DHEX,
    output logic [6:0]           THEX,
    output logic                 LED_D
);

    localparam int unsigned PAD_W   = NUM_DIG * 4;
    localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic                 w_pk;
    logic                 w_rise;
    state_t               w_state_d;
    logic [DATA_W-1:0]    w_snap_d;
    logic [DATA_W-1:0]    w_src;
    logic [PAD_W-1:0]     w_pad;
    logic [NUM_DIG*7-1:0] w_dhex_d;
    logic [BLINK_W-1:0]   w_blink_d;
    logic                 w_led_d_d;

    state_t               r_state;
    logic [DATA_W-1:0]    r_snap;
    logic                 r_done_prev;
    logic [BLINK_W-1:0]   r_blink;
    logic [DATA_W-1:0]    r_led_b;
    logic [NUM_DIG*7-1:0] r_dhex;
    logic [6:0]           r_thex;
    logic                 r_led_d;

    display_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_debounce (
        .CLK   (CLK),
        .RST   (RST),
        .i_raw (PEEKb),
        .o_pk  (w_pk)
    );

    assign w_rise = DONE & ~r_done_prev;

    always_comb begin
        w_state_d = r_state;
        w_snap_d  = r_snap;
        unique case (r_state)
            S_REG: begin
                if (w_rise) begin
                    w_state_d = S_DONE;
                    w_snap_d  = REG;
                end else if (w_pk) begin
                    w_state_d = S_BUS;
                end
            end
            S_BUS: begin
                if (w_rise) begin
                    w_state_d = S_DONE;
                    w_snap_d  = REG;
                end else if (!w_pk) begin
                    w_state_d = S_REG;
                end
            end
            S_DONE: begin
                if (!DONE) begin
                    w_state_d = w_pk ? S_BUS : S_REG;
                end
            end
            default: w_state_d = S_REG;
        endcase
    end

    // Source follows the next state so a transition is visible after the same edge.
    always_comb begin
        unique case (w_state_d)
            S_BUS:   w_src = BUS;
            S_DONE:  w_src = w_pk ? BUS : w_snap_d;
            default: w_src = REG;
        endcase
    end

    assign w_pad = PAD_W'(w_src);

    for (genvar gi = 0; gi < NUM_DIG; gi++) begin : g_dig
        assign w_dhex_d[gi*7 +: 7] = hex_to_seg(w_pad[gi*4 +: 4]);
    end

    always_comb begin
        w_blink_d = '0;
        w_led_d_d = 1'b0;
        if (w_state_d == S_DONE) begin
            if (r_state != S_DONE) begin
                w_led_d_d = 1'b1;
            end else if (r_blink == BLINK_W'(BLINK_CYCLES - 1)) begin
                w_led_d_d = ~r_led_d;
            end else begin
                w_blink_d = r_blink + 1'b1;
                w_led_d_d = r_led_d;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_REG;
            r_snap      <= '0;
            r_done_prev <= 1'b0;
            r_blink     <= '0;
            r_led_b     <= '0;
            r_dhex      <= {NUM_DIG{SEG_BLANK}};
            r_thex      <= SEG_BLANK;
            r_led_d     <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_snap      <= w_snap_d;
            r_done_prev <= DONE;
            r_blink     <= w_blink_d;
            r_led_b     <= BUS;
            r_dhex      <= w_dhex_d;
            r_thex      <= hex_to_seg(4'(TIME));
            r_led_d     <= w_led_d_d;
        end
    end

    assign LED_B = r_led_b;
    assign DHEX  = r_dhex;
    assign THEX  = r_thex;
    assign LED_D = r_led_d;

endmodule
